// File: rtl/pwm_audio_decoder.sv
// Receive side of the 1-bit PWM audio link: recovers one sample per frame, tracks note
// on/off from silent frames and measures the sawtooth period in frames.
module pwm_audio_decoder #(
    parameter int SAMPLE_BITS    = 7,
    parameter int GAP_FRAMES     = 16,
    parameter int WRAP_THRESHOLD = 64,
    parameter int PERIOD_BITS    = 12,
    parameter int LENGTH_BITS    = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pwm_in,
    output logic [SAMPLE_BITS-1:0] sample,
    output logic                   sample_valid,
    output logic                   silent,
    output logic                   note_active,
    output logic                   note_start,
    output logic                   note_end,
    output logic [LENGTH_BITS-1:0] note_length,
    output logic [PERIOD_BITS-1:0] period,
    output logic                   period_valid
);

    localparam int GAP_BITS = $clog2(GAP_FRAMES + 1);
    localparam logic [SAMPLE_BITS-1:0] POS_MAX = '1;
    localparam logic [SAMPLE_BITS:0]   WRAP_TH = (SAMPLE_BITS + 1)'(WRAP_THRESHOLD);
    localparam logic [GAP_BITS-1:0]    GAP_END = GAP_BITS'(GAP_FRAMES);

    typedef enum logic [1:0] {
        ST_SILENT  = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_TRACK   = 2'd2
    } state_t;

    logic [SAMPLE_BITS-1:0] r_frame_pos;
    logic [SAMPLE_BITS:0]   r_high_cnt;

    logic [SAMPLE_BITS-1:0] r_sample;
    logic                   r_sample_valid;
    logic                   r_silent;

    state_t                 r_state;
    logic [LENGTH_BITS-1:0] r_len;
    logic [GAP_BITS-1:0]    r_run;
    logic [SAMPLE_BITS-1:0] r_prev;
    logic [PERIOD_BITS-1:0] r_per_cnt;
    logic                   r_note_active;
    logic                   r_note_start;
    logic                   r_note_end;
    logic [LENGTH_BITS-1:0] r_note_length;
    logic [PERIOD_BITS-1:0] r_period;
    logic                   r_period_valid;

    logic                   w_frame_end;
    logic [SAMPLE_BITS:0]   w_final;
    logic                   w_silent;
    logic [SAMPLE_BITS-1:0] w_sample;
    logic [SAMPLE_BITS:0]   w_drop;
    logic                   w_wrap;
    logic [LENGTH_BITS-1:0] w_len_inc;
    logic [PERIOD_BITS-1:0] w_per_inc;
    logic [PERIOD_BITS-1:0] w_period_new;
    logic [GAP_BITS-1:0]    w_run_inc;
    logic                   w_gap_hit;

    // The last cycle's pwm_in is folded in combinationally so the frame decodes on its own end edge.
    assign w_frame_end  = (r_frame_pos == POS_MAX);
    assign w_final      = r_high_cnt + {{SAMPLE_BITS{1'b0}}, pwm_in};
    assign w_silent     = (w_final == '0);
    assign w_sample     = SAMPLE_BITS'(w_final - (SAMPLE_BITS + 1)'(1));

    assign w_drop       = {1'b0, r_prev} - {1'b0, w_sample};
    assign w_wrap       = (r_prev >= w_sample) && (w_drop >= WRAP_TH);

    assign w_len_inc    = (r_len == '1) ? r_len : r_len + LENGTH_BITS'(1);
    assign w_per_inc    = (r_per_cnt == '1) ? r_per_cnt : r_per_cnt + PERIOD_BITS'(1);
    assign w_period_new = w_per_inc;
    assign w_run_inc    = r_run + GAP_BITS'(1);
    assign w_gap_hit    = (w_run_inc == GAP_END);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_pos <= '0;
            r_high_cnt  <= '0;
        end else begin
            r_frame_pos <= r_frame_pos + SAMPLE_BITS'(1);
            r_high_cnt  <= w_frame_end ? '0 : w_final;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sample       <= '0;
            r_sample_valid <= 1'b0;
            r_silent       <= 1'b0;
        end else begin
            r_sample_valid <= w_frame_end;
            if (w_frame_end) begin
                r_silent <= w_silent;
                if (!w_silent) begin
                    r_sample <= w_sample;
                end
            end
        end
    end

    // Note tracker; steps on the same edge as the decoder so note_start lines up with sample_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_SILENT;
            r_len          <= '0;
            r_run          <= '0;
            r_prev         <= '0;
            r_per_cnt      <= '0;
            r_note_active  <= 1'b0;
            r_note_start   <= 1'b0;
            r_note_end     <= 1'b0;
            r_note_length  <= '0;
            r_period       <= '0;
            r_period_valid <= 1'b0;
        end else begin
            r_note_start   <= 1'b0;
            r_note_end     <= 1'b0;
            r_period_valid <= 1'b0;
            if (w_frame_end) begin
                case (r_state)
                    ST_SILENT: begin
                        if (!w_silent) begin
                            r_state       <= ST_ACQUIRE;
                            r_note_start  <= 1'b1;
                            r_note_active <= 1'b1;
                            r_len         <= LENGTH_BITS'(1);
                            r_run         <= '0;
                            r_prev        <= w_sample;
                        end
                    end
                    ST_ACQUIRE, ST_TRACK: begin
                        if (w_silent) begin
                            // Generator phase is frozen while silent, so len/prev/per_cnt hold.
                            if (w_gap_hit) begin
                                r_state       <= ST_SILENT;
                                r_note_end    <= 1'b1;
                                r_note_length <= r_len;
                                r_note_active <= 1'b0;
                                r_run         <= '0;
                            end else begin
                                r_run <= w_run_inc;
                            end
                        end else begin
                            r_len  <= w_len_inc;
                            r_run  <= '0;
                            r_prev <= w_sample;
                            if (r_state == ST_TRACK) begin
                                if (w_wrap) begin
                                    r_period       <= w_period_new;
                                    r_period_valid <= 1'b1;
                                    r_per_cnt      <= '0;
                                end else begin
                                    r_per_cnt <= w_per_inc;
                                end
                            end else if (w_wrap) begin
                                r_state   <= ST_TRACK;
                                r_per_cnt <= '0;
                            end
                        end
                    end
                    default: begin
                        r_state <= ST_SILENT;
                    end
                endcase
            end
        end
    end

    assign sample       = r_sample;
    assign sample_valid = r_sample_valid;
    assign silent       = r_silent;
    assign note_active  = r_note_active;
    assign note_start   = r_note_start;
    assign note_end     = r_note_end;
    assign note_length  = r_note_length;
    assign period       = r_period;
    assign period_valid = r_period_valid;

endmodule

// File: tb/tb_pwm_audio_decoder.sv
// Bench for pwm_audio_decoder: frame-level model of the decoder checked every cycle,
// plus literal expectations for decode values, periods, note lengths and pulse counts.
module tb_pwm_audio_decoder;

    localparam int SB    = 7;
    localparam int GAP   = 16;
    localparam int WRAP  = 64;
    localparam int PB    = 5;   // small so period saturation is reachable quickly
    localparam int LB    = 7;   // small so note_length saturation is reachable quickly
    localparam int FRAME = 1 << SB;
    localparam int PMAX  = (1 << PB) - 1;
    localparam int LMAX  = (1 << LB) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          pwm_in;
    logic [SB-1:0] sample;
    logic          sample_valid;
    logic          silent;
    logic          note_active;
    logic          note_start;
    logic          note_end;
    logic [LB-1:0] note_length;
    logic [PB-1:0] period;
    logic          period_valid;

    pwm_audio_decoder #(
        .SAMPLE_BITS   (SB),
        .GAP_FRAMES    (GAP),
        .WRAP_THRESHOLD(WRAP),
        .PERIOD_BITS   (PB),
        .LENGTH_BITS   (LB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pwm_in      (pwm_in),
        .sample      (sample),
        .sample_valid(sample_valid),
        .silent      (silent),
        .note_active (note_active),
        .note_start  (note_start),
        .note_end    (note_end),
        .note_length (note_length),
        .period      (period),
        .period_valid(period_valid)
    );

    always #20 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 0;

    // expected outputs
    int exp_sample, exp_silent, exp_active, exp_len_out, exp_period;
    int exp_sv, exp_ns, exp_ne, exp_pv;
    // note-level model state
    bit m_in_note, m_tracking;
    int m_nidx, m_run, m_prev, m_last_wrap;

    // observations for literal checks
    int cnt_sv = 0, cnt_ns = 0, cnt_ne = 0, last_len = -1;
    int q_per[$];
    int acc;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_sample = 0; exp_silent = 0; exp_active = 0; exp_len_out = 0; exp_period = 0;
        exp_sv = 0; exp_ns = 0; exp_ne = 0; exp_pv = 0;
        m_in_note = 0; m_tracking = 0; m_nidx = 0; m_run = 0; m_prev = 0; m_last_wrap = 0;
    endtask

    task automatic clear_pulses();
        exp_sv = 0; exp_ns = 0; exp_ne = 0; exp_pv = 0;
    endtask

    // One decoded frame with h high cycles; period measured as the distance between
    // wrap frames counted in non-silent frames of the note.
    task automatic model_step(input int h);
        int s;
        bit sil;
        sil = (h == 0);
        exp_sv = 1;
        exp_silent = sil;
        if (!sil) exp_sample = h - 1;
        s = exp_sample;
        if (!m_in_note) begin
            if (!sil) begin
                m_in_note = 1; m_tracking = 0; m_nidx = 1; m_run = 0; m_prev = s;
                exp_ns = 1; exp_active = 1;
            end
        end else if (sil) begin
            m_run++;
            if (m_run == GAP) begin
                exp_ne = 1;
                exp_len_out = (m_nidx > LMAX) ? LMAX : m_nidx;
                exp_active = 0;
                m_in_note = 0;
            end
        end else begin
            m_run = 0;
            m_nidx++;
            if (m_prev >= s && (m_prev - s) >= WRAP) begin
                if (m_tracking) begin
                    exp_period = ((m_nidx - m_last_wrap) > PMAX) ? PMAX : (m_nidx - m_last_wrap);
                    exp_pv = 1;
                end
                m_tracking = 1;
                m_last_wrap = m_nidx;
            end
            m_prev = s;
        end
    endtask

    task automatic drive_frame(input int h);
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            rst = 1'b0;
            pwm_in = (i < h);
            if (i == 0) clear_pulses();
        end
        model_step(h);
    endtask

    task automatic partial_frame(input int h, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst = 1'b0;
            pwm_in = (i < h);
            if (i == 0) clear_pulses();
        end
    endtask

    // Leaves rst high at a negedge; the next drive_frame releases it in frame cycle 0.
    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1;
        pwm_in = 1'b0;
        model_reset();
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic silence(input int n);
        for (int k = 0; k < n; k++) drive_frame(0);
    endtask

    // Generator-like sawtooth: 14-bit phase accumulator, sample is its top SB bits.
    task automatic tone(input int inc, input int n);
        for (int k = 0; k < n; k++) begin
            drive_frame(((acc >> 7) & 127) + 1);
            acc = (acc + inc) & 16383;
        end
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    function automatic int qget(input int idx);
        return (idx < q_per.size()) ? q_per[idx] : -1;
    endfunction

    always begin
        @(posedge clk);
        #1;
        if (chk_en) begin
            chk("sample", int'(sample), exp_sample);
            chk("sample_valid", int'(sample_valid), exp_sv);
            chk("silent", int'(silent), exp_silent);
            chk("note_active", int'(note_active), exp_active);
            chk("note_start", int'(note_start), exp_ns);
            chk("note_end", int'(note_end), exp_ne);
            chk("note_length", int'(note_length), exp_len_out);
            chk("period", int'(period), exp_period);
            chk("period_valid", int'(period_valid), exp_pv);
            if (period_valid) q_per.push_back(int'(period));
            if (sample_valid) cnt_sv++;
            if (note_start) cnt_ns++;
            if (note_end) begin
                cnt_ne++;
                last_len = int'(note_length);
            end
        end
    end

    initial begin
        rst = 1'b1;
        pwm_in = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk_en = 1;

        // Silence after reset
        silence(20);
        settle();
        chk("idle_sv_count", cnt_sv, 20);
        chk("idle_note_start_count", cnt_ns, 0);
        chk("idle_silent", int'(silent), 1);
        $display("idle: 20 silent frames, sample_valid count %0d", cnt_sv);

        // Decode boundaries: 1, 65, 128 high cycles
        drive_frame(1);
        settle();
        chk("dec_sample_1", int'(sample), 0);
        chk("dec_start_with_valid", int'(note_start && sample_valid), 1);
        drive_frame(65);
        settle();
        chk("dec_sample_65", int'(sample), 64);
        drive_frame(128);
        settle();
        chk("dec_sample_128", int'(sample), 127);
        chk("dec_not_silent", int'(silent), 0);
        silence(GAP);
        settle();
        chk("dec_start_count", cnt_ns, 1);
        chk("dec_note_length", last_len, 3);
        $display("decode: samples 0/64/127, note_length %0d", last_len);

        // Ramp with a pause inside the note
        acc = 0;
        q_per.delete();
        tone(700, 60);
        silence(10);
        tone(700, 40);
        silence(GAP);
        settle();
        chk("ramp_period_count", q_per.size(), 3);
        chk("ramp_period_0", qget(0), 23);
        chk("ramp_period_1", qget(1), 24);
        chk("ramp_period_2", qget(2), 23);
        chk("ramp_note_length", last_len, 100);
        chk("ramp_end_count", cnt_ne, 2);
        $display("ramp: %0d periods, note_length %0d", q_per.size(), last_len);

        // Period and length saturation
        acc = 0;
        q_per.delete();
        tone(300, 150);
        silence(GAP);
        settle();
        chk("sat_period_count", q_per.size(), 1);
        chk("sat_period", qget(0), PMAX);
        chk("sat_note_length", last_len, LMAX);
        $display("saturation: period %0d, note_length %0d", qget(0), last_len);

        // Reset mid-frame while tracking, then a fresh note
        acc = 0;
        q_per.delete();
        tone(1024, 40);
        chk("pre_reset_period", qget(0), 16);
        partial_frame(((acc >> 7) & 127) + 1, 50);
        do_reset(1);
        settle();
        chk("reset_active", int'(note_active), 0);
        chk("reset_period", int'(period), 0);
        q_per.delete();
        acc = 0;
        tone(1024, 20);
        silence(GAP);
        settle();
        chk("post_reset_no_period", q_per.size(), 0);
        chk("post_reset_note_length", last_len, 20);
        $display("reset: new note length %0d, period pulses %0d", last_len, q_per.size());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pwm_audio_decoder.md
Name: pwm_audio_decoder

Overview:
- Receive end of the 1-bit PWM audio stream produced by the music block. Recovers the 7-bit sample carried in each 128-cycle PWM frame.
- Detects note on/off from silent frames and measures the sawtooth period in frames, which identifies the note.
- Used in loopback self-test and bench checking of the music output. Both blocks run on the same 25 MHz clock.

Parameters:
- SAMPLE_BITS, 7, bits per PWM frame index; frame length is 2**SAMPLE_BITS cycles (128).
- GAP_FRAMES, 16, number of consecutive silent frames that ends a note.
- WRAP_THRESHOLD, 64, minimum sample drop (prev − new) that counts as a sawtooth wrap.
- PERIOD_BITS, 12, width of the period counter; saturates at all-ones.
- LENGTH_BITS, 16, width of the note-length counter; saturates at all-ones.

Ports:
- clk  in  1  system clock, 25 MHz.
- rst  in  1  synchronous reset, active-high.
- pwm_in  in  1  PWM stream, frame-aligned to this block's frame counter.
- sample  out  SAMPLE_BITS  last decoded sample.
- sample_valid  out  1  one-cycle pulse when sample/silent update.
- silent  out  1  last frame had zero high cycles.
- note_active  out  1  high while a note is in progress.
- note_start  out  1  one-cycle pulse: first non-silent frame after SILENT.
- note_end  out  1  one-cycle pulse: GAP_FRAMES-th consecutive silent frame.
- note_length  out  LENGTH_BITS  non-silent frames in the ended note; valid with note_end.
- period  out  PERIOD_BITS  frames between the last two wraps.
- period_valid  out  1  one-cycle pulse when period updates.

Behaviour:
- Reset: all outputs 0, frame_pos = 0, state SILENT, all counters 0.
  - Alignment is defined by releasing rst on the same edge as the generator's reset; no resync logic.
  - Reset asserted mid-frame or mid-note aborts everything with no pulses.
- Frame counter: frame_pos counts 0..2**SAMPLE_BITS−1 and wraps, one step per clk.
  - high_cnt (SAMPLE_BITS+1 bits) accumulates pwm_in over the frame.
  - In the frame_pos = max cycle, final = high_cnt + pwm_in, and high_cnt clears for the next frame.
- Decode: the generator drives high for (sample+1) cycles while a note plays and 0 cycles when silent.
  - Registered on the edge after the last frame cycle:
    - final = 0 → silent = 1, sample holds its previous value.
    - otherwise → silent = 0, sample = final − 1.
    - final = 128 → sample = 127.
  - sample_valid pulses one cycle later, every frame.
  - Latency: last PWM cycle of frame N → sample_valid on the next cycle.
- FSM, stepped once per decoded frame:
  - SILENT:
    - Non-silent frame → ACQUIRE, note_start pulse, note_active = 1, len = 1, silent_run = 0, prev = sample.
  - ACQUIRE (no wrap seen yet in this note):
    - Wrap (prev ≥ new and prev − new ≥ WRAP_THRESHOLD) → TRACK, per_cnt = 0.
  - TRACK:
    - Each non-silent frame increments per_cnt (saturating).
    - On a wrap: period = per_cnt + 1, period_valid pulse, per_cnt = 0.
  - In ACQUIRE and TRACK:
    - Non-silent frame: len += 1 (saturating), silent_run = 0, prev = sample.
    - Silent frame: silent_run += 1; len, prev and per_cnt hold, since the generator's phase freezes while silent.
    - silent_run reaching GAP_FRAMES → SILENT, note_end pulse, note_length = len, note_active = 0.
  - A silent run shorter than GAP_FRAMES does not end the note.
  - A non-silent frame resets silent_run and continues the same note.
- Simultaneous events: a wrap on the same frame as the ACQUIRE→TRACK transition produces no period_valid.
- Saturation: period = 2**PERIOD_BITS−1 is reported if per_cnt saturated; note_length saturates likewise.
- Pulse outputs last exactly one clk. note_start and sample_valid coincide on the same cycle.

Test Plan:
- Reset release, pwm_in = 0 for 20 frames → sample_valid every 128 cycles, silent = 1, no note_start/note_end, all other outputs 0.
- Frames with high counts 1, 65, 128 → sample = 0, 64, 127 with silent = 0; note_start pulses once, coinciding with the first sample_valid.
- Generator-like ramp with increment 12/frame on a 14-bit accumulator (LOW_D_SHARP) → first wrap enters TRACK; subsequent period values alternate 1365/1366 with one period_valid per wrap.
- Short note: 16405 non-silent frames, then 5469 silent frames → note_end on the 16th silent frame with note_length = 16405, note_active drops the same cycle.
- 10 silent frames inside a note, then tone resumes → no note_end, note_length excludes the 10 frames, period unaffected by the pause.
- Assert rst for 1 cycle mid-frame during TRACK → all outputs 0 next cycle; after release, a new note restarts in ACQUIRE with no stale period_valid.
